// File: rtl/mult_matrix_revert_core.sv
// De-skew stage for the systolic multiplier output: lane j is delayed by (size - j) registers
// so that a diagonally skewed vector leaves as one aligned parallel word.
module mult_matrix_revert_core #(
  parameter int unsigned data_size = 4,
  parameter int unsigned size      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [data_size*size-1:0] input_stream,
  output logic [data_size*size-1:0] output_stream
);

  for (genvar j = 0; j < size; j++) begin : g_lane
    localparam int unsigned Depth = size - j;
    localparam int unsigned Msb   = (size - j) * data_size - 1;

    logic [data_size-1:0] pipe_q [Depth];

    // Stage 0 samples the input; the last stage drives the output slice directly.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < Depth; k++) begin
          pipe_q[k] <= '0;
        end
      end else begin
        pipe_q[0] <= input_stream[Msb -: data_size];
        for (int k = 1; k < Depth; k++) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end

    assign output_stream[Msb -: data_size] = pipe_q[Depth-1];
  end

endmodule

// File: tb/tb_mult_matrix_revert_core.sv
// Directed bench for the de-skew stage: a table of {rst, input, expected} steps plus
// per-lane pulse, back-to-back streaming and single-lane (size=1) sequences.
module tb_mult_matrix_revert_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] input_stream;
  logic [11:0] output_stream;
  logic [3:0]  in1;
  logic [3:0]  out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_matrix_revert_core #(.data_size(4), .size(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_stream (input_stream),
    .output_stream(output_stream)
  );

  mult_matrix_revert_core #(.data_size(4), .size(1)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .input_stream (in1),
    .output_stream(out1)
  );

  typedef struct {
    logic        r;
    logic [11:0] din;
    logic [11:0] exp;
    string       name;
  } vec_t;

  vec_t tbl [$];

  task automatic step(input logic r, input logic [11:0] din);
    rst          = r;
    input_stream = din;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] pack(input logic [3:0] l0, input logic [3:0] l1,
                                       input logic [3:0] l2);
    return {l0, l1, l2};
  endfunction

  logic [3:0] rows [6][3];

  initial begin
    rst          = 1'b1;
    input_stream = '0;
    in1          = '0;

    // Reset with all-ones input
    tbl.push_back('{1'b1, 12'hFFF, 12'h000, "reset0"});
    tbl.push_back('{1'b1, 12'hFFF, 12'h000, "reset1"});
    // Skewed 3x3 matrix
    tbl.push_back('{1'b0, 12'h100, 12'h000, "mat_e0"});
    tbl.push_back('{1'b0, 12'h420, 12'h000, "mat_e1"});
    tbl.push_back('{1'b0, 12'h753, 12'h123, "mat_e2"});
    tbl.push_back('{1'b0, 12'h086, 12'h456, "mat_e3"});
    tbl.push_back('{1'b0, 12'h009, 12'h789, "mat_e4"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "mat_e5"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "mat_e6"});
    // Mid-stream reset at edge 3
    tbl.push_back('{1'b0, 12'h100, 12'h000, "mrst_e0"});
    tbl.push_back('{1'b0, 12'h420, 12'h000, "mrst_e1"});
    tbl.push_back('{1'b0, 12'h753, 12'h123, "mrst_e2"});
    tbl.push_back('{1'b1, 12'h086, 12'h000, "mrst_e3"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "mrst_e4"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "mrst_e5"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "mrst_e6"});
    // Max values
    tbl.push_back('{1'b0, 12'hF00, 12'h000, "max_e0"});
    tbl.push_back('{1'b0, 12'hFF0, 12'h000, "max_e1"});
    tbl.push_back('{1'b0, 12'hFFF, 12'hFFF, "max_e2"});
    tbl.push_back('{1'b0, 12'h0FF, 12'hFFF, "max_e3"});
    tbl.push_back('{1'b0, 12'h00F, 12'hFFF, "max_e4"});
    tbl.push_back('{1'b0, 12'h000, 12'h000, "max_e5"});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].din);
      check(tbl[i].name, output_stream, tbl[i].exp);
    end

    // Per-lane latency: pulse A on lane j at edge 0 shows up after edge 2-j only
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 12'h000);
      for (int e = 0; e < 5; e++) begin
        logic [11:0] pulse;
        pulse = 12'hA << ((2 - j) * 4);
        step(1'b0, (e == 0) ? pulse : 12'h000);
        check($sformatf("pulse_l%0d_e%0d", j, e), output_stream,
              (e == 2 - j) ? pulse : 12'h000);
      end
    end

    // Back-to-back: two matrices fed skewed with no gap
    rows[0] = '{4'h1, 4'h2, 4'h3};
    rows[1] = '{4'h4, 4'h5, 4'h6};
    rows[2] = '{4'h7, 4'h8, 4'h9};
    rows[3] = '{4'hA, 4'hB, 4'hC};
    rows[4] = '{4'hD, 4'hE, 4'hF};
    rows[5] = '{4'h3, 4'hC, 4'h5};
    step(1'b1, 12'h000);
    for (int t = 0; t < 9; t++) begin
      logic [3:0]  ln [3];
      logic [11:0] exp;
      for (int j = 0; j < 3; j++) begin
        ln[j] = (t - j >= 0 && t - j < 6) ? rows[t-j][j] : 4'h0;
      end
      step(1'b0, pack(ln[0], ln[1], ln[2]));
      exp = (t >= 2 && t <= 7) ? pack(rows[t-2][0], rows[t-2][1], rows[t-2][2]) : 12'h000;
      check($sformatf("b2b_e%0d", t), output_stream, exp);
    end

    // size=1 instance: a single register
    rst = 1'b1;
    in1 = 4'h7;
    @(posedge clk); #1;
    checks++;
    if (out1 !== 4'h0) begin
      errors++;
      $display("FAIL s1_reset: got %h, expected 0", out1);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      v   = 4'(i * 5 + 3);
      in1 = v;
      @(posedge clk); #1;
      checks++;
      if (out1 !== v) begin
        errors++;
        $display("FAIL s1_pass%0d: got %h, expected %h", i, out1, v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
